// File: rtl/pipemem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface pipemem_stage_if #(
  parameter int DATA_W = 32
) ();
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata,
    input  dm_ack
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata,
    output dm_ack
  );
endinterface

// File: rtl/pipemem_stage.sv
// MIPS32 MEM stage: EX/MEM and MEM/WB registers around a req/ack data-memory port with timeout.
// Optional macro MEM_ALIGN_CHECK_EN rejects memory ops whose address is not word aligned.
module pipemem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              evalid,
  input  logic [DATA_W-1:0] ealu,
  input  logic [DATA_W-1:0] eb,
  input  logic [4:0]        ern,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  output logic              mstall,
  pipemem_stage_if.master   dm,
  output logic              wvalid,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [4:0]        wrn,
  output logic [DATA_W-1:0] walu,
  output logic [DATA_W-1:0] wmo,
  output logic              merr
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  // EX/MEM register
  logic              r_mvalid;
  logic [DATA_W-1:0] r_malu;
  logic [DATA_W-1:0] r_mb;
  logic [4:0]        r_mrn;
  logic              r_mwreg;
  logic              r_mm2reg;
  logic              r_mwmem;

  // MEM/WB register
  logic              r_wvalid;
  logic              r_wwreg;
  logic              r_wm2reg;
  logic [4:0]        r_wrn;
  logic [DATA_W-1:0] r_walu;
  logic [DATA_W-1:0] r_wmo;

  logic [0:0]        r_state;
  logic [7:0]        r_cnt;

  logic w_mem_op;
  logic w_misalign;
  logic w_access;
  logic w_timeout_hit;
  logic w_fail;
  logic w_stall;

  assign w_mem_op = r_mvalid & (r_mm2reg | r_mwmem);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_mem_op & (r_malu[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_access      = w_mem_op & ~w_misalign;
  // The final wait cycle gives up on the ack and lets the op leave MEM with an error.
  assign w_timeout_hit = (r_state == ST_WAIT) & ~dm.dm_ack & (r_cnt == LP_LAST);
  assign w_fail        = w_timeout_hit | w_misalign;
  assign w_stall       = w_access & ~dm.dm_ack & ~w_timeout_hit;

  assign dm.dm_req   = w_access;
  assign dm.dm_we    = r_mwmem;
  assign dm.dm_addr  = r_malu;
  assign dm.dm_wdata = r_mb;

  assign mstall = w_stall;
  assign merr   = w_fail;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mvalid <= 1'b0;
      r_malu   <= '0;
      r_mb     <= '0;
      r_mrn    <= 5'd0;
      r_mwreg  <= 1'b0;
      r_mm2reg <= 1'b0;
      r_mwmem  <= 1'b0;
    end else if (!w_stall) begin
      r_mvalid <= evalid;
      r_malu   <= ealu;
      r_mb     <= eb;
      r_mrn    <= ern;
      r_mwreg  <= evalid & ewreg;
      r_mm2reg <= evalid & em2reg;
      r_mwmem  <= evalid & ewmem;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 8'd0;
          if (w_access && !dm.dm_ack) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dm.dm_ack || w_timeout_hit) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // A stalled cycle hands write-back a bubble; an aborted access keeps its slot but writes nothing.
  always_ff @(posedge clock) begin
    if (reset || w_stall) begin
      r_wvalid <= 1'b0;
      r_wwreg  <= 1'b0;
      r_wm2reg <= 1'b0;
      r_wrn    <= 5'd0;
      r_walu   <= '0;
      r_wmo    <= '0;
    end else begin
      r_wvalid <= r_mvalid;
      r_wwreg  <= r_mwreg & (r_mrn != 5'd0) & ~w_fail;
      r_wm2reg <= r_mm2reg;
      r_wrn    <= r_mrn;
      r_walu   <= r_malu;
      r_wmo    <= (w_access && r_mm2reg && dm.dm_ack) ? dm.dm_rdata : '0;
    end
  end

  assign wvalid = r_wvalid;
  assign wwreg  = r_wwreg;
  assign wm2reg = r_wm2reg;
  assign wrn    = r_wrn;
  assign walu   = r_walu;
  assign wmo    = r_wmo;

endmodule

// File: tb/tb_pipemem_stage.sv
// Directed self-checking bench for pipemem_stage; data memory is driven by hand from each test task.
module tb_pipemem_stage;

  localparam int DW = 32;
  localparam int TO = 15;

  logic          clock;
  logic          reset;
  logic          evalid;
  logic [DW-1:0] ealu;
  logic [DW-1:0] eb;
  logic [4:0]    ern;
  logic          ewreg;
  logic          em2reg;
  logic          ewmem;
  logic          mstall;
  logic          wvalid;
  logic          wwreg;
  logic          wm2reg;
  logic [4:0]    wrn;
  logic [DW-1:0] walu;
  logic [DW-1:0] wmo;
  logic          merr;

  int errors = 0;
  int checks = 0;

  pipemem_stage_if #(.DATA_W(DW)) dm_bus ();

  pipemem_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock  (clock),
    .reset  (reset),
    .evalid (evalid),
    .ealu   (ealu),
    .eb     (eb),
    .ern    (ern),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .ewmem  (ewmem),
    .mstall (mstall),
    .dm     (dm_bus),
    .wvalid (wvalid),
    .wwreg  (wwreg),
    .wm2reg (wm2reg),
    .wrn    (wrn),
    .walu   (walu),
    .wmo    (wmo),
    .merr   (merr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_e(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [4:0] rn, input logic wr, input logic m2, input logic wm);
    evalid = v; ealu = a; eb = b; ern = rn; ewreg = wr; em2reg = m2; ewmem = wm;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL rst_mstall: got %0b want 0", mstall); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", dm_bus.dm_req); end
    checks++; if (dm_bus.dm_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", dm_bus.dm_we); end
    checks++; if (dm_bus.dm_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", dm_bus.dm_addr); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %0b want 0", wvalid); end
    checks++; if (wwreg !== 1'b0) begin errors++; $display("FAIL rst_wwreg: got %0b want 0", wwreg); end
    checks++; if (wrn !== 5'd0) begin errors++; $display("FAIL rst_wrn: got %0d want 0", wrn); end
    checks++; if (walu !== 32'h0) begin errors++; $display("FAIL rst_walu: got %h want 0", walu); end
    checks++; if (wmo !== 32'h0) begin errors++; $display("FAIL rst_wmo: got %h want 0", wmo); end
    checks++; if (merr !== 1'b0) begin errors++; $display("FAIL rst_merr: got %0b want 0", merr); end
    reset = 1'b0;
    $display("reset: outputs checked idle");
  endtask

  task automatic test_load_zero_wait();
    set_e(1'b1, 32'h100, '0, 5'd5, 1'b1, 1'b1, 1'b0);
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'hDEADBEEF;
    next_cycle();
    checks++; if (dm_bus.dm_req !== 1'b1) begin errors++; $display("FAIL lw0_req: got %0b want 1", dm_bus.dm_req); end
    checks++; if (dm_bus.dm_we !== 1'b0) begin errors++; $display("FAIL lw0_we: got %0b want 0", dm_bus.dm_we); end
    checks++; if (dm_bus.dm_addr !== 32'h100) begin errors++; $display("FAIL lw0_addr: got %h want 100", dm_bus.dm_addr); end
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL lw0_mstall: got %0b want 0", mstall); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = '0;
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL lw0_wvalid: got %0b want 1", wvalid); end
    checks++; if (wmo !== 32'hDEADBEEF) begin errors++; $display("FAIL lw0_wmo: got %h want deadbeef", wmo); end
    checks++; if (wm2reg !== 1'b1) begin errors++; $display("FAIL lw0_wm2reg: got %0b want 1", wm2reg); end
    checks++; if (wrn !== 5'd5) begin errors++; $display("FAIL lw0_wrn: got %0d want 5", wrn); end
    checks++; if (wwreg !== 1'b1) begin errors++; $display("FAIL lw0_wwreg: got %0b want 1", wwreg); end
    $display("lw  r5 <- [0x100] zero-wait: wmo=%h", wmo);
  endtask

  task automatic test_store_wait();
    set_e(1'b1, 32'h104, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1);
    dm_bus.dm_ack = 1'b0;
    next_cycle();
    set_e(1'b1, 32'h55, '0, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mstall !== 1'b1) begin errors++; $display("FAIL sw_stall%0d: got %0b want 1", i, mstall); end
      checks++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_we !== 1'b1) begin errors++; $display("FAIL sw_req%0d: req=%0b we=%0b want 1 1", i, dm_bus.dm_req, dm_bus.dm_we); end
      checks++; if (dm_bus.dm_addr !== 32'h104 || dm_bus.dm_wdata !== 32'h12345678) begin errors++; $display("FAIL sw_bus%0d: addr=%h wdata=%h want 104 12345678", i, dm_bus.dm_addr, dm_bus.dm_wdata); end
      if (i > 0) begin
        checks++; if (wvalid !== 1'b0 || wwreg !== 1'b0) begin errors++; $display("FAIL sw_bubble%0d: wvalid=%0b wwreg=%0b want 0 0", i, wvalid, wwreg); end
      end
      next_cycle();
    end
    checks++; if (wvalid !== 1'b0 || wwreg !== 1'b0) begin errors++; $display("FAIL sw_bubble3: wvalid=%0b wwreg=%0b want 0 0", wvalid, wwreg); end
    dm_bus.dm_ack = 1'b1;
    #1;
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL sw_ack_release: got %0b want 0", mstall); end
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b1 || wwreg !== 1'b0) begin errors++; $display("FAIL sw_wb: wvalid=%0b wwreg=%0b want 1 0", wvalid, wwreg); end
    checks++; if (dm_bus.dm_req !== 1'b0 || mstall !== 1'b0) begin errors++; $display("FAIL sw_next_req: req=%0b mstall=%0b want 0 0", dm_bus.dm_req, mstall); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wwreg !== 1'b1 || wrn !== 5'd7 || walu !== 32'h55) begin errors++; $display("FAIL sw_held_add: wwreg=%0b wrn=%0d walu=%h want 1 7 55", wwreg, wrn, walu); end
    $display("sw  [0x104] <- 12345678 after 3 wait cycles, held add r7 then completed");
  endtask

  task automatic test_nonmem();
    set_e(1'b1, 32'h11, '0, 5'd0, 1'b1, 1'b0, 1'b0);
    dm_bus.dm_ack = 1'b1;
    next_cycle();
    checks++; if (dm_bus.dm_req !== 1'b0 || mstall !== 1'b0) begin errors++; $display("FAIL add_req: req=%0b mstall=%0b want 0 0", dm_bus.dm_req, mstall); end
    set_e(1'b1, 32'h404, '0, 5'd31, 1'b1, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wvalid !== 1'b1 || wwreg !== 1'b0) begin errors++; $display("FAIL add_r0: wvalid=%0b wwreg=%0b want 1 0", wvalid, wwreg); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL jal_req: got %0b want 0", dm_bus.dm_req); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    checks++; if (wwreg !== 1'b1 || wrn !== 5'd31 || walu !== 32'h404) begin errors++; $display("FAIL jal_wb: wwreg=%0b wrn=%0d walu=%h want 1 31 404", wwreg, wrn, walu); end
    checks++; if (wm2reg !== 1'b0 || wmo !== 32'h0) begin errors++; $display("FAIL jal_wmo: wm2reg=%0b wmo=%h want 0 0", wm2reg, wmo); end
    $display("add r0 then jal r31: walu=%h", walu);
  endtask

  task automatic test_timeout();
    int  n_stall = 0;
    int  n_merr  = 0;
    bit  done    = 0;
    set_e(1'b1, 32'h200, '0, 5'd9, 1'b1, 1'b1, 1'b0);
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = 32'hBAD0BAD0;
    next_cycle();
    set_e(1'b1, 32'h33, '0, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TO + 10 && !done; i++) begin
      if (merr) n_merr++;
      if (mstall) n_stall++;
      else done = 1;
      if (!done) next_cycle();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_release: stall not released within %0d cycles", TO + 10); end
    checks++; if (n_stall != TO) begin errors++; $display("FAIL to_stall_len: got %0d want %0d", n_stall, TO); end
    checks++; if (n_merr != 1 || merr !== 1'b1) begin errors++; $display("FAIL to_merr: pulses=%0d now=%0b want 1 1", n_merr, merr); end
    next_cycle();
    checks++; if (wwreg !== 1'b0 || wmo !== 32'h0) begin errors++; $display("FAIL to_wb: wwreg=%0b wmo=%h want 0 0", wwreg, wmo); end
    checks++; if (merr !== 1'b0 || mstall !== 1'b0) begin errors++; $display("FAIL to_after: merr=%0b mstall=%0b want 0 0", merr, mstall); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wwreg !== 1'b1 || wrn !== 5'd3 || walu !== 32'h33) begin errors++; $display("FAIL to_resume: wwreg=%0b wrn=%0d walu=%h want 1 3 33", wwreg, wrn, walu); end
    $display("lw  r9 <- [0x200] timed out after %0d stall cycles", n_stall);
  endtask

  task automatic test_reset_mid();
    set_e(1'b1, 32'h300, '0, 5'd4, 1'b1, 1'b1, 1'b0);
    dm_bus.dm_ack = 1'b0;
    next_cycle();
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (mstall !== 1'b1) begin errors++; $display("FAIL rm_stall: got %0b want 1", mstall); end
    reset = 1'b1;
    next_cycle();
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'hCAFEF00D;
    reset = 1'b0;
    #1;
    checks++; if (dm_bus.dm_req !== 1'b0 || mstall !== 1'b0 || merr !== 1'b0) begin errors++; $display("FAIL rm_ctrl: req=%0b mstall=%0b merr=%0b want 0 0 0", dm_bus.dm_req, mstall, merr); end
    checks++; if (wvalid !== 1'b0 || wwreg !== 1'b0 || wmo !== 32'h0 || wrn !== 5'd0) begin errors++; $display("FAIL rm_w: wvalid=%0b wwreg=%0b wmo=%h wrn=%0d want 0 0 0 0", wvalid, wwreg, wmo, wrn); end
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    checks++; if (wvalid !== 1'b0 || wwreg !== 1'b0 || wmo !== 32'h0) begin errors++; $display("FAIL rm_late_ack: wvalid=%0b wwreg=%0b wmo=%h want 0 0 0", wvalid, wwreg, wmo); end
    $display("lw  r4 <- [0x300] abandoned by reset, late ack ignored");
  endtask

  task automatic test_back_to_back();
    set_e(1'b1, 32'h10, '0, 5'd1, 1'b1, 1'b1, 1'b0);
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'hA1A1A1A1;
    next_cycle();
    checks++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_addr !== 32'h10 || mstall !== 1'b0) begin errors++; $display("FAIL b2b_op1: req=%0b addr=%h mstall=%0b want 1 10 0", dm_bus.dm_req, dm_bus.dm_addr, mstall); end
    set_e(1'b1, 32'h14, '0, 5'd2, 1'b1, 1'b1, 1'b0);
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    #1;
    checks++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_addr !== 32'h14 || mstall !== 1'b1) begin errors++; $display("FAIL b2b_op2: req=%0b addr=%h mstall=%0b want 1 14 1", dm_bus.dm_req, dm_bus.dm_addr, mstall); end
    checks++; if (wmo !== 32'hA1A1A1A1 || wrn !== 5'd1 || wwreg !== 1'b1) begin errors++; $display("FAIL b2b_wb1: wmo=%h wrn=%0d wwreg=%0b want a1a1a1a1 1 1", wmo, wrn, wwreg); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %0b want 0", wvalid); end
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'hB2B2B2B2;
    #1;
    checks++; if (mstall !== 1'b0) begin errors++; $display("FAIL b2b_release: got %0b want 0", mstall); end
    next_cycle();
    dm_bus.dm_ack = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b1 || wmo !== 32'hB2B2B2B2 || wrn !== 5'd2) begin errors++; $display("FAIL b2b_wb2: wvalid=%0b wmo=%h wrn=%0d want 1 b2b2b2b2 2", wvalid, wmo, wrn); end
    checks++; if (dm_bus.dm_req !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %0b want 0", dm_bus.dm_req); end
    $display("lw  r1 <- [0x10], lw r2 <- [0x14] back to back: wmo=%h", wmo);
  endtask

  task automatic test_misaligned();
    set_e(1'b1, 32'h102, '0, 5'd6, 1'b1, 1'b1, 1'b0);
    dm_bus.dm_ack = 1'b1;
    dm_bus.dm_rdata = 32'h77777777;
    next_cycle();
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (dm_bus.dm_req !== 1'b0 || mstall !== 1'b0 || merr !== 1'b1) begin errors++; $display("FAIL mis_ctrl: req=%0b mstall=%0b merr=%0b want 0 0 1", dm_bus.dm_req, mstall, merr); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wwreg !== 1'b0 || wmo !== 32'h0) begin errors++; $display("FAIL mis_wb: wwreg=%0b wmo=%h want 0 0", wwreg, wmo); end
`else
    checks++; if (dm_bus.dm_req !== 1'b1 || dm_bus.dm_addr !== 32'h102 || merr !== 1'b0) begin errors++; $display("FAIL mis_pass: req=%0b addr=%h merr=%0b want 1 102 0", dm_bus.dm_req, dm_bus.dm_addr, merr); end
    set_e(1'b0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    checks++; if (wwreg !== 1'b1 || wmo !== 32'h77777777) begin errors++; $display("FAIL mis_wb: wwreg=%0b wmo=%h want 1 77777777", wwreg, wmo); end
`endif
    dm_bus.dm_ack = 1'b0;
    $display("lw  r6 <- [0x102] unaligned: wwreg=%0b wmo=%h", wwreg, wmo);
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_nonmem();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
